rvvi_mem_arbiter: RTL and testbench
===================================

# rvvi_mem_arbiter

Two-requester arbiter and sequencer in front of the single-port testbench memory. It shares one synchronous memory port between an instruction-fetch requester (I) and a load/store requester (D). It checks every request against the ROM/RAM map, suppressing and flagging illegal accesses. It returns read data to the requester through a req/valid handshake.

## Interface
- ROM_START_ADDR, 'h8000: first byte address of ROM.
- ROM_BYTE_SIZE, 'h20000: ROM size in bytes. RAM starts at ROM_START_ADDR+ROM_BYTE_SIZE.
- RAM_BYTE_SIZE, 'h20000: RAM size in bytes.
- MAX_D_STREAK, 4: maximum number of consecutive D grants while IReq is pending (≥1).
- Clk  in  1  single clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IReq  in  1  fetch request; held with IAddr stable until IValid.
- IAddr  in  32  fetch byte address; bits [1:0] ignored.
- IValid  out  1  one-cycle response strobe for I.
- IErr  out  1  qualifies IValid: fetch outside ROM.
- IData  out  32  fetched word, valid with IValid.
- DReq  in  1  load/store request; held with DWe/DAddr/DBe/DWData stable until DValid.
- DWe  in  1  1 = store, 0 = load.
- DAddr  in  32  data byte address; bits [1:0] ignored.
- DBe  in  4  byte enables.
- DWData  in  32  store data.
- DValid  out  1  one-cycle response strobe for D.
- DErr  out  1  qualifies DValid: load outside ROM∪RAM, or store outside RAM.
- DRData  out  32  load data (zero for stores), valid with DValid.
- MRd  out  1  memory read strobe, one cycle.
- MWr  out  1  memory write strobe, one cycle.
- MAddr  out  32  memory byte address, word-aligned ({addr[31:2],2'b00}).
- MBe  out  4  memory byte enables (4'hF for fetches).
- MWData  out  32  memory write data.
- MRData  in  32  memory read data; valid the cycle after the MRd edge.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** arbitrate on the rising edge.
  - D wins by default.
  - I wins if IReq=1 and streak==MAX_D_STREAK, or if DReq=0.
  - Winner is legal: load M* registers and go to ISSUE.
  - Winner is illegal: go to RESP with Err=1 and no memory strobe.
- **ISSUE:** MRd or MWr is high for exactly this cycle. Go to WAIT.
- **WAIT:** capture MRData (loads and fetches) or 0 (stores). Go to RESP.
- **RESP:** the winner's Valid is high for one cycle, with Err and data. Return to IDLE.
- Only one transaction is in flight at a time; the loser stays pending.
- Streak counter:
  - Increments on each D grant made while IReq=1.
  - Clears on every I grant and whenever IReq=0 in IDLE.
  - Saturates at MAX_D_STREAK.
- Legality is checked on the full 32-bit byte address, inclusive bounds, with no wrap-around. The bound sums are 33-bit.
- Fetch is legal only in ROM. Load is legal in ROM or RAM. Store is legal only in RAM.
- A store with DBe=0 is legal: MWr pulses with MBe=0.
- A request still high on the edge after its Valid cycle is a new request.
- Reset, including mid-transaction:
  - FSM goes to IDLE and the streak clears.
  - All outputs go to 0 immediately.
  - The in-flight response is discarded; no Valid is issued for it.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Legal access, request sampled at edge k:
  - M* strobe is high in cycle k..k+1.
  - MRData is sampled at edge k+2.
  - Valid is high in cycle k+3..k+4.
  - Request-to-Valid latency is 3 cycles.
- Illegal access, request sampled at edge k: Err and Valid are high in cycle k+1..k+2. Latency is 1 cycle.
- Back-to-back: the next arbitration happens at the edge ending RESP. Throughput is one legal access per 4 cycles.
- IData and DRData hold their last value until the next Valid of the same port. Err is 0 whenever Valid is 0.

## Test plan
- Single fetch:
  - Stimulus: IReq=1, IAddr='h8004, memory word 'h00000013.
  - Response: MRd pulses with MAddr='h8004, MBe='hF; 3 cycles after the request edge, IValid=1, IData='h00000013, IErr=0.
- Store then load:
  - Stimulus: D store to 'h28000 with DWData='hAABBCCDD, DBe='b0011; then a load from the same address.
  - Response: MWr with MBe='h3; the load returns DRData='h0000CCDD (memory pre-zeroed).
- Permission errors:
  - Stimulus: store to ROM 'h8000; fetch from 'h28000; load from 'h48000.
  - Response: each gives Valid+Err after 1 cycle; MRd and MWr never assert.
- Fairness:
  - Stimulus: DReq and IReq held continuously, MAX_D_STREAK=4.
  - Response: grant order is D,D,D,D,I,D,D,D,D,I.
- Boundaries:
  - Stimulus: loads at 'h7FFF, 'h8000, 'h27FFF, 'h28000, 'h47FFF, 'h48000, 'hFFFFFFFF.
  - Response: Err = 1,0,0,0,0,1,1.
- Reset mid-op:
  - Stimulus: assert Reset during WAIT of a load.
  - Response: all outputs go to 0 asynchronously and no DValid follows; after release, a new IReq completes normally in 3 cycles.

Source files
------------

// File: rtl/rvvi_mem_arbiter.sv
// rvvi_mem_arbiter: shares one synchronous memory port between fetch (I) and load/store (D)
// requesters, checking each access against the ROM/RAM map and returning data via req/valid.
module rvvi_mem_arbiter #(
    parameter logic [31:0] ROM_START_ADDR = 32'h8000,
    parameter logic [31:0] ROM_BYTE_SIZE  = 32'h20000,
    parameter logic [31:0] RAM_BYTE_SIZE  = 32'h20000,
    parameter int          MAX_D_STREAK   = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic        IValid,
    output logic        IErr,
    output logic [31:0] IData,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [3:0]  DBe,
    input  logic [31:0] DWData,
    output logic        DValid,
    output logic        DErr,
    output logic [31:0] DRData,
    output logic        MRd,
    output logic        MWr,
    output logic [31:0] MAddr,
    output logic [3:0]  MBe,
    output logic [31:0] MWData,
    input  logic [31:0] MRData
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [32:0] ROM_LO = {1'b0, ROM_START_ADDR};
    localparam logic [32:0] ROM_HI = ROM_LO + {1'b0, ROM_BYTE_SIZE};
    localparam logic [32:0] RAM_HI = ROM_HI + {1'b0, RAM_BYTE_SIZE};
    state_t state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic is_i_q, is_st_q, err_q;
    logic [31:0] rdata_q;
    logic mrd_q, mwr_q, i_valid_q, i_err_q, d_valid_q, d_err_q;
    logic [31:0] maddr_q, mwdata_q, idata_q, drdata_q;
    logic [3:0] mbe_q;
    logic grant_i, gnt, in_rom, in_ram, legal;
    logic [31:0] g_addr;
    always_comb begin
        grant_i  = IReq && (streak_q == SW'(MAX_D_STREAK) || !DReq);
        gnt      = IReq || DReq;
        g_addr   = grant_i ? IAddr : DAddr;
        in_rom   = {1'b0, g_addr} >= ROM_LO && {1'b0, g_addr} < ROM_HI;
        in_ram   = {1'b0, g_addr} >= ROM_HI && {1'b0, g_addr} < RAM_HI;
        legal    = grant_i ? in_rom : DWe ? in_ram : (in_rom || in_ram);
        state_d  = state_q == IDLE  ? (gnt ? (legal ? ISSUE : RESP) : IDLE) :
                   state_q == ISSUE ? WAIT :
                   state_q == WAIT  ? RESP : IDLE;
        // A non-I grant with IReq high implies streak < MAX, so the increment never overflows.
        streak_d = state_q != IDLE ? streak_q : (!IReq || grant_i) ? '0 : streak_q + SW'(1);
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            is_i_q    <= 1'b0;
            is_st_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            mrd_q     <= 1'b0;
            mwr_q     <= 1'b0;
            maddr_q   <= '0;
            mbe_q     <= '0;
            mwdata_q  <= '0;
            i_valid_q <= 1'b0;
            i_err_q   <= 1'b0;
            idata_q   <= '0;
            d_valid_q <= 1'b0;
            d_err_q   <= 1'b0;
            drdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            mrd_q     <= 1'b0;
            mwr_q     <= 1'b0;
            i_valid_q <= 1'b0;
            i_err_q   <= 1'b0;
            d_valid_q <= 1'b0;
            d_err_q   <= 1'b0;
            if (state_q == IDLE && gnt) begin
                is_i_q  <= grant_i;
                is_st_q <= !grant_i && DWe;
                err_q   <= !legal;
                rdata_q <= '0;
                if (legal) begin
                    mrd_q    <= grant_i || !DWe;
                    mwr_q    <= !grant_i && DWe;
                    maddr_q  <= {g_addr[31:2], 2'b00};
                    mbe_q    <= grant_i ? 4'hF : DBe;
                    mwdata_q <= (!grant_i && DWe) ? DWData : '0;
                end
            end
            if (state_q == WAIT)
                rdata_q <= is_st_q ? '0 : MRData;
            if (state_q == RESP) begin
                i_valid_q <= is_i_q;
                i_err_q   <= is_i_q && err_q;
                d_valid_q <= !is_i_q;
                d_err_q   <= !is_i_q && err_q;
                if (is_i_q)
                    idata_q <= rdata_q;
                else
                    drdata_q <= rdata_q;
            end
        end
    end
    assign MRd    = mrd_q;
    assign MWr    = mwr_q;
    assign MAddr  = maddr_q;
    assign MBe    = mbe_q;
    assign MWData = mwdata_q;
    assign IValid = i_valid_q;
    assign IErr   = i_err_q;
    assign IData  = idata_q;
    assign DValid = d_valid_q;
    assign DErr   = d_err_q;
    assign DRData = drdata_q;
endmodule

// File: tb/tb_rvvi_mem_arbiter.sv
// tb_rvvi_mem_arbiter: directed and randomized transactions checked against a transaction-level
// model of the address map, latencies and memory contents.
module tb_rvvi_mem_arbiter;
    localparam int MAXS = 4;
    logic Clk = 0, Reset = 1;
    logic IReq = 0, DReq = 0, DWe = 0;
    logic [31:0] IAddr = 0, DAddr = 0, DWData = 0, MRData = 0;
    logic [3:0] DBe = 0;
    logic IValid, IErr, DValid, DErr, MRd, MWr;
    logic [31:0] IData, DRData, MAddr, MWData;
    logic [3:0] MBe;
    int compared = 0, mismatched = 0;
    logic [31:0] mem [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];

    rvvi_mem_arbiter #(.MAX_D_STREAK(MAXS)) dut (
        .Clk(Clk), .Reset(Reset),
        .IReq(IReq), .IAddr(IAddr), .IValid(IValid), .IErr(IErr), .IData(IData),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DBe(DBe), .DWData(DWData),
        .DValid(DValid), .DErr(DErr), .DRData(DRData),
        .MRd(MRd), .MWr(MWr), .MAddr(MAddr), .MBe(MBe), .MWData(MWData), .MRData(MRData)
    );

    always #5 Clk = ~Clk;

    // Single-port synchronous memory: read data appears the cycle after the MRd edge.
    always @(posedge Clk) begin
        logic [31:0] w;
        if (MRd) MRData <= mem.exists(MAddr[31:2]) ? mem[MAddr[31:2]] : 32'h0;
        if (MWr) begin
            w = mem.exists(MAddr[31:2]) ? mem[MAddr[31:2]] : 32'h0;
            for (int b = 0; b < 4; b++) if (MBe[b]) w[8*b +: 8] = MWData[8*b +: 8];
            mem[MAddr[31:2]] = w;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input bit is_i, input bit we, input logic [31:0] a);
        longint x = a;
        bit rom = x >= 'h8000 && x < 'h28000;
        bit ram = x >= 'h28000 && x < 'h48000;
        return is_i ? rom : we ? ram : (rom || ram);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
    endfunction

    task automatic txn(input bit is_i, input bit we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output logic err_o, output logic [31:0] data_o);
        bit ok = legal(is_i, we, a);
        bit st = !is_i && we;
        logic [31:0] exp_data = st ? 32'h0 : ref_read(a);
        int vcyc = 0, strobes = 0, other = 0;
        string t = is_i ? "fetch" : st ? "store" : "load";
        err_o = 1'bx;
        data_o = 'x;
        if (is_i) begin IReq = 1; IAddr = a; end
        else begin DReq = 1; DWe = we; DAddr = a; DBe = be; DWData = wd; end
        for (int c = 1; c <= 8 && vcyc == 0; c++) begin
            @(posedge Clk); #1;
            if (c == 1 && ok) begin
                check({t, "_mrd"}, {31'b0, MRd}, {31'b0, !st});
                check({t, "_mwr"}, {31'b0, MWr}, {31'b0, st});
                check({t, "_maddr"}, MAddr, a & 32'hFFFF_FFFC);
                check({t, "_mbe"}, {28'b0, MBe}, {28'b0, is_i ? 4'hF : be});
                if (st) check({t, "_mwdata"}, MWData, wd);
            end
            strobes += int'(MRd) + int'(MWr);
            other += is_i ? int'(DValid) : int'(IValid);
            if (is_i ? IValid : DValid) begin
                vcyc = c;
                err_o = is_i ? IErr : DErr;
                data_o = is_i ? IData : DRData;
                IReq = 0;
                DReq = 0;
            end
        end
        IReq = 0;
        DReq = 0;
        check({t, "_latency"}, 32'(vcyc), ok ? 32'd4 : 32'd2);
        check({t, "_strobes"}, 32'(strobes), ok ? 32'd1 : 32'd0);
        check({t, "_other_valid"}, 32'(other), 32'd0);
        check({t, "_err"}, {31'b0, err_o}, {31'b0, !ok});
        if (ok) check({t, "_data"}, data_o, exp_data);
        if (ok && st) begin
            logic [31:0] w = ref_read(a);
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            ref_mem[a[31:2]] = w;
        end
        @(posedge Clk); #1;
        check({t, "_valid_one_cycle"}, {30'b0, IValid, DValid}, 32'd0);
        check({t, "_err_idle"}, {30'b0, IErr, DErr}, 32'd0);
    endtask

    initial begin
        logic e;
        logic [31:0] d, a;
        int n, dv, kind;
        logic [31:0] baddr [7] = '{32'h7FFF, 32'h8000, 32'h27FFF, 32'h28000, 32'h47FFF, 32'h48000, 32'hFFFFFFFF};
        logic berr [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            mem[30'h2000 + 30'(i)] = d;
            ref_mem[30'h2000 + 30'(i)] = d;
        end
        mem[30'h2001] = 32'h00000013;
        ref_mem[30'h2001] = 32'h00000013;
        #3;
        check("reset_ctrl", {20'b0, IValid, IErr, DValid, DErr, MRd, MWr, 2'b0, MBe}, 32'd0);
        check("reset_maddr", MAddr, 32'd0);
        check("reset_idata", IData, 32'd0);
        check("reset_drdata", DRData, 32'd0);
        #9 Reset = 0;
        @(posedge Clk); #1;

        txn(1, 0, 32'h8004, 4'h0, 0, e, d);
        check("single_fetch_data", d, 32'h00000013);
        txn(0, 1, 32'h28000, 4'b0011, 32'hAABBCCDD, e, d);
        check("store_data_zero", d, 32'h0);
        txn(0, 0, 32'h28000, 4'hF, 0, e, d);
        check("store_load_data", d, 32'h0000CCDD);
        txn(0, 1, 32'h28004, 4'h0, 32'h12345678, e, d);
        txn(0, 0, 32'h28004, 4'hF, 0, e, d);
        check("be0_store_noop", d, 32'h0);

        txn(0, 1, 32'h8000, 4'hF, 32'hDEADBEEF, e, d);
        txn(1, 0, 32'h28000, 4'h0, 0, e, d);
        txn(0, 0, 32'h48000, 4'hF, 0, e, d);

        for (int i = 0; i < 7; i++) begin
            txn(0, 0, baddr[i], 4'hF, 0, e, d);
            check($sformatf("boundary_%h", baddr[i]), {31'b0, e}, {31'b0, berr[i]});
        end

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            a = kind == 0 ? 32'h8000 + $urandom_range(0, 63) :
                kind == 1 ? 32'h28000 + $urandom_range(0, 63) :
                kind == 2 ? 32'h47FC0 + $urandom_range(0, 127) : $urandom;
            kind = $urandom_range(0, 2);
            txn(kind == 0, kind == 2, a, 4'($urandom), $urandom, e, d);
        end

        IReq = 1; IAddr = 32'h8010;
        DReq = 1; DWe = 0; DAddr = 32'h28010; DBe = 4'hF;
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(posedge Clk); #1;
            if (IValid || DValid) begin
                check($sformatf("fair_grant_%0d_is_i", n), {31'b0, IValid}, {31'b0, n % (MAXS + 1) == MAXS});
                n++;
            end
        end
        IReq = 0; DReq = 0;
        check("fair_count", 32'(n), 32'd10);
        @(posedge Clk); #1;
        @(posedge Clk); #1;

        DReq = 1; DWe = 0; DAddr = 32'h28000; DBe = 4'hF;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1;
        #1;
        check("rst_mid_ctrl", {20'b0, IValid, IErr, DValid, DErr, MRd, MWr, 2'b0, MBe}, 32'd0);
        check("rst_mid_maddr", MAddr, 32'd0);
        check("rst_mid_mwdata", MWData, 32'd0);
        check("rst_mid_idata", IData, 32'd0);
        check("rst_mid_drdata", DRData, 32'd0);
        DReq = 0;
        @(posedge Clk); #1;
        Reset = 0;
        dv = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clk); #1;
            dv += int'(DValid);
        end
        check("rst_no_dvalid", 32'(dv), 32'd0);
        txn(1, 0, 32'h8004, 4'h0, 0, e, d);
        check("post_reset_fetch", d, 32'h00000013);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
